packet_assembler: RTL and testbench

Input assembler for the GPU pipeline. Sits between the UART receiver and the top-level triangle register file. It frames the raw UART byte stream into one triangle packet:
- a sync byte, then 54 payload bytes (27 little-endian Q-format words), then an optional checksum;
- per payload byte it emits the register-file write index and data;
- once per complete, valid frame it emits a single `pc_ready` pulse that starts the vertex shader.

---
 rtl/gpu_pkg.sv | 16 +
 rtl/packet_assembler_gap_timer.sv | 47 ++++
 rtl/packet_assembler.sv | 139 +++++++++++++
 tb/tb_packet_assembler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU pipeline definitions.
// Holds the input-assembler state encoding and the frame constants. The
// top-level register-file decode uses the same constants, so that decode and
// the assembler always agree on the frame layout.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } ia_state_t;

  localparam logic [7:0] IA_SYNC_BYTE = 8'hA5;
  localparam int         IA_NUM_BYTES = 54;

endpackage

// File: rtl/packet_assembler_gap_timer.sv
// gap_timer: saturating inter-byte gap counter.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear_i     - restart the count from zero (a byte arrived)
//   enable_i    - count while high; held at zero while low
//   expired_o   - registered, high once the count reaches TIMEOUT_CYCLES
module gap_timer
  import gpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          expired_q;

  // Saturates at LIMIT so a long silence cannot wrap back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == LIMIT);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/packet_assembler.sv
// packet_assembler: frames the UART byte stream into one triangle packet.
// A sync byte opens a frame, NUM_BYTES payload bytes follow and each one is
// written to the register file (idx/data_out/update_reg). A complete frame
// produces one pc_ready pulse; an inter-byte gap of TIMEOUT_CYCLES aborts it
// with a frame_err pulse.
// Build option: define PKT_CHECKSUM_EN to require a trailing XOR checksum
// byte; a mismatch then gives frame_err instead of pc_ready.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   rx_data, rx_done    - received byte and its one-cycle strobe
//   idx, data_out       - register-file write index and byte
//   update_reg          - one-cycle write strobe
//   pc_ready            - one-cycle pulse per accepted frame
//   busy                - frame in progress
//   frame_err           - one-cycle pulse on timeout or checksum mismatch
module packet_assembler
  import gpu_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = IA_SYNC_BYTE,
  parameter int         NUM_BYTES      = IA_NUM_BYTES,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [5:0] idx,
  output logic [7:0] data_out,
  output logic       update_reg,
  output logic       pc_ready,
  output logic       busy,
  output logic       frame_err
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_BYTES - 1);

  ia_state_t  state_q;
  logic [5:0] cnt_q;
  logic [5:0] idx_q;
  logic [7:0] data_out_q;
  logic       update_reg_q;
  logic       pc_ready_q;
  logic       frame_err_q;
  logic       expired;
`ifdef PKT_CHECKSUM_EN
  logic [7:0] acc_q;
`endif

  // The timer only runs inside a frame and restarts on every strobe.
  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (rx_done || (state_q == IDLE)),
    .enable_i (state_q != IDLE),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      data_out_q   <= '0;
      update_reg_q <= 1'b0;
      pc_ready_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      acc_q        <= '0;
`endif
    end else begin
      update_reg_q <= 1'b0;
      pc_ready_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_done && (rx_data == SYNC_BYTE)) begin
            cnt_q   <= '0;
`ifdef PKT_CHECKSUM_EN
            acc_q   <= '0;
`endif
            state_q <= DATA;
          end
        end
        DATA: begin
          // A strobe in the timeout cycle is still accepted.
          if (rx_done) begin
            update_reg_q <= 1'b1;
            idx_q        <= cnt_q;
            data_out_q   <= rx_data;
`ifdef PKT_CHECKSUM_EN
            acc_q        <= acc_q ^ rx_data;
`endif
            if (cnt_q == LAST_IDX) begin
              cnt_q   <= '0;
`ifdef PKT_CHECKSUM_EN
              state_q <= CHECK;
`else
              pc_ready_q <= 1'b1;
              state_q    <= IDLE;
`endif
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end else if (expired) begin
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
        end
`ifdef PKT_CHECKSUM_EN
        CHECK: begin
          if (rx_done) begin
            if (rx_data == acc_q) begin
              pc_ready_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end else if (expired) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idx        = idx_q;
  assign data_out   = data_out_q;
  assign update_reg = update_reg_q;
  assign pc_ready   = pc_ready_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_packet_assembler.sv
module tb_packet_assembler;

  localparam int TMO = 100;
`ifdef PKT_CHECKSUM_EN
  localparam int PC_ON_LAST = 0;
`else
  localparam int PC_ON_LAST = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [5:0] idx;
  logic [7:0] data_out;
  logic       update_reg;
  logic       pc_ready;
  logic       busy;
  logic       frame_err;

  packet_assembler #(
    .SYNC_BYTE     (8'hA5),
    .NUM_BYTES     (54),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .idx       (idx),
    .data_out  (data_out),
    .update_reg(update_reg),
    .pc_ready  (pc_ready),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output log, sampled on the falling edge.
  logic [5:0] log_idx[$];
  logic [7:0] log_dat[$];
  int n_pc = 0, n_err = 0, n_pc_last = 0, n_both = 0;

  always @(negedge clk) begin
    if (update_reg) begin
      log_idx.push_back(idx);
      log_dat.push_back(data_out);
    end
    if (pc_ready) begin
      n_pc++;
      if (update_reg && idx == 6'd53) n_pc_last++;
    end
    if (frame_err) n_err++;
    if (pc_ready && frame_err) n_both++;
  end

  task automatic clear_log();
    log_idx.delete();
    log_dat.delete();
    n_pc = 0; n_err = 0; n_pc_last = 0;
  endtask

  logic [7:0] tx_buf[0:63];
  int         tx_len;
  logic [7:0] exp_data[0:53];

  task automatic build_frame(input int bad_ck, input int sync_at7);
    logic [7:0] ck;
    logic [7:0] p;
    ck = 8'h00;
    tx_buf[0] = 8'hA5;
    for (int i = 0; i < 54; i++) begin
      p = 8'(i);
      if (sync_at7 != 0 && i == 7) p = 8'hA5;
      exp_data[i] = p;
      tx_buf[1+i] = p;
      ck = ck ^ p;
    end
`ifdef PKT_CHECKSUM_EN
    tx_buf[55] = (bad_ck != 0) ? (ck ^ 8'h01) : ck;
    tx_len = 56;
`else
    tx_len = 55;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_stream(input int b2b);
    for (int i = 0; i < tx_len; i++) begin
      @(negedge clk);
      rx_data = tx_buf[i];
      rx_done = 1'b1;
      if (b2b == 0) begin
        @(negedge clk);
        rx_done = 1'b0;
      end
    end
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_wr, input int exp_pc,
                             input int exp_err, input int exp_pc_last);
    int n;
    repeat (5) @(negedge clk);
    check({tag, ".writes"}, log_idx.size(), exp_wr);
    n = (log_idx.size() < exp_wr) ? log_idx.size() : exp_wr;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.idx%0d", tag, i), log_idx[i], i);
      check($sformatf("%s.dat%0d", tag, i), log_dat[i], exp_data[i]);
    end
    check({tag, ".pc_ready"}, n_pc, exp_pc);
    check({tag, ".frame_err"}, n_err, exp_err);
    check({tag, ".pc_on_last"}, n_pc_last, exp_pc_last);
    check({tag, ".busy_end"}, busy, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst.idx", idx, 0);
    check("rst.data", data_out, 0);
    check("rst.upd", update_reg, 0);
    check("rst.pc", pc_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.err", frame_err, 0);
    reset = 1'b0;
    clear_log();

    // IDLE filtering, then a normal frame
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 1);
    repeat (3) @(negedge clk);
    check("filt.writes", log_idx.size(), 0);
    check("filt.busy", busy, 0);
    check("filt.pc_err", n_pc + n_err, 0);
    build_frame(0, 0);
    send_stream(0);
    check_frame("full", 54, 1, 0, PC_ON_LAST);
    clear_log();

    // Gaps below the limit are tolerated; a full-length gap aborts
    send_byte(8'hA5, 0);
    check("tmo.busy_rise", busy, 1);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 90);
    check("tmo.no_err_short_gap", n_err, 0);
    for (int i = 5; i < 10; i++) send_byte(8'(8'h10 + i), 0);
    for (int i = 0; i < TMO + 20 && n_err == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("tmo.err", n_err, 1);
    check("tmo.pc", n_pc, 0);
    check("tmo.busy", busy, 0);
    check("tmo.writes", log_idx.size(), 10);
    clear_log();
    build_frame(0, 0);
    send_stream(0);
    check_frame("after_tmo", 54, 1, 0, PC_ON_LAST);
    clear_log();

`ifdef PKT_CHECKSUM_EN
    // Corrupted checksum
    build_frame(1, 0);
    send_stream(0);
    check_frame("badck", 54, 0, 1, 0);
    clear_log();
`endif

    // Reset mid-frame, with one-cycle write latency checked on the way
    send_byte(8'hA5, 0);
    @(negedge clk);
    rx_data = 8'h11;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("lat.upd", update_reg, 1);
    check("lat.idx", idx, 0);
    check("lat.data", data_out, 8'h11);
    for (int i = 1; i < 20; i++) send_byte(8'(8'h40 + i), 0);
    reset = 1'b1;
    @(negedge clk);
    check("mrst.idx", idx, 0);
    check("mrst.data", data_out, 0);
    check("mrst.upd", update_reg, 0);
    check("mrst.busy", busy, 0);
    check("mrst.pc_err", {pc_ready, frame_err}, 0);
    reset = 1'b0;
    clear_log();
    build_frame(0, 0);
    send_stream(0);
    check_frame("after_rst", 54, 1, 0, PC_ON_LAST);
    clear_log();

    // Back-to-back strobes with a sync value inside the payload
    build_frame(0, 1);
    send_stream(1);
    check_frame("b2b", 54, 1, 0, PC_ON_LAST);
    check("excl.pc_err", n_both, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
